// File: rtl/load_wb_unit.sv
// Load/writeback unit: sequences one data-memory load at a time and merges its
// result with ALU results onto a single register-file write port.
// Optional macro LOAD_MISALIGN_CHECK_EN aborts misaligned LH/LHU/LW loads with o_misalign.
module load_wb_unit #(
    parameter int unsigned N  = 32,
    parameter int unsigned AW = 5
) (
    input  logic          i_clk,
    input  logic          i_arst,
    input  logic          i_alu_valid,
    input  logic [AW-1:0] i_alu_rd,
    input  logic [N-1:0]  i_alu_result,
    input  logic          i_ld_valid,
    input  logic [AW-1:0] i_ld_rd,
    input  logic [N-1:0]  i_ld_addr,
    input  logic [2:0]    i_ld_funct3,
    output logic          o_ld_busy,
    output logic          o_mem_req,
    output logic [N-1:0]  o_mem_addr,
    input  logic          i_mem_gnt,
    input  logic          i_mem_rvalid,
    input  logic [N-1:0]  i_mem_rdata,
    output logic          o_rf_we,
    output logic [AW-1:0] o_rf_waddr,
    output logic [N-1:0]  o_rf_wdata,
    output logic          o_stall,
    output logic          o_misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ld_rd;
    logic [1:0]    r_ld_lane;
    logic [2:0]    r_ld_funct3;
    logic [N-1:0]  r_mem_addr;
    logic          r_mem_req;
    logic          r_busy;
    logic          r_pend_valid;
    logic [AW-1:0] r_pend_rd;
    logic [N-1:0]  r_pend_data;
    logic          r_rf_we;
    logic [AW-1:0] r_rf_waddr;
    logic [N-1:0]  r_rf_wdata;

    logic          w_ld_acc;
    logic          w_ld_wr;
    logic          w_alu_acc;
    logic          w_mis;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [N-1:0]  w_ld_data;

    assign w_ld_acc  = i_ld_valid && !r_busy;
    assign w_ld_wr   = (r_state == S_WAIT) && i_mem_rvalid;
    assign w_alu_acc = i_alu_valid && !r_pend_valid;

`ifdef LOAD_MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_mis = ((i_ld_funct3 == 3'b001 || i_ld_funct3 == 3'b101) && i_ld_addr[0])
                || ((i_ld_funct3 == 3'b010) && (i_ld_addr[1:0] != 2'b00));

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) r_misalign <= 1'b0;
        else        r_misalign <= w_ld_acc && w_mis;
    end

    assign o_misalign = r_misalign;
`else
    assign w_mis      = 1'b0;
    assign o_misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; a misaligned load spends its single busy cycle in WB
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_ld_acc)     w_state_nxt = w_mis ? S_WB : S_REQ;
            S_REQ:  if (i_mem_gnt)    w_state_nxt = S_WAIT;
            S_WAIT: if (i_mem_rvalid) w_state_nxt = S_WB;
            S_WB:                     w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        w_byte = i_mem_rdata[{r_ld_lane, 3'b000} +: 8];
        w_half = i_mem_rdata[{r_ld_lane[1], 4'b0000} +: 16];
        case (r_ld_funct3)
            3'b000:  w_ld_data = {{(N-8){w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {{(N-8){1'b0}}, w_byte};
            3'b001:  w_ld_data = {{(N-16){w_half[15]}}, w_half};
            3'b101:  w_ld_data = {{(N-16){1'b0}}, w_half};
            default: w_ld_data = i_mem_rdata;
        endcase
    end

    // Load capture, memory request and write-port arbitration (load > pending > ALU)
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_ld_rd      <= '0;
            r_ld_lane    <= '0;
            r_ld_funct3  <= '0;
            r_mem_addr   <= '0;
            r_mem_req    <= 1'b0;
            r_busy       <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_rd    <= '0;
            r_pend_data  <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
        end else begin
            if (w_ld_acc) begin
                r_ld_rd     <= i_ld_rd;
                r_ld_lane   <= i_ld_addr[1:0];
                r_ld_funct3 <= i_ld_funct3;
                if (!w_mis) r_mem_addr <= {i_ld_addr[N-1:2], 2'b00};
            end
            r_mem_req <= (w_state_nxt == S_REQ);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_rf_we   <= 1'b0;
            if (w_ld_wr) begin
                if (r_ld_rd != '0) begin
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= r_ld_rd;
                    r_rf_wdata <= w_ld_data;
                end
                if (w_alu_acc) begin
                    r_pend_valid <= 1'b1;
                    r_pend_rd    <= i_alu_rd;
                    r_pend_data  <= i_alu_result;
                end
            end else if (r_pend_valid) begin
                r_pend_valid <= 1'b0;
                if (r_pend_rd != '0) begin
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= r_pend_rd;
                    r_rf_wdata <= r_pend_data;
                end
            end else if (w_alu_acc && (i_alu_rd != '0)) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= i_alu_rd;
                r_rf_wdata <= i_alu_result;
            end
        end
    end

    assign o_ld_busy  = r_busy;
    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;
    assign o_rf_we    = r_rf_we;
    assign o_rf_waddr = r_rf_waddr;
    assign o_rf_wdata = r_rf_wdata;
    assign o_stall    = r_pend_valid;

endmodule

// File: doc/load_wb_unit.md
LOAD_WB_UNIT -- requirements
Module: load_wb_unit

Interface
REQ-001 Parameter N, default 32, data/address width.
REQ-002 Parameter AW, default 5, register-address width (x0..x31).
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_arst  in  1  reset, asynchronous, active-high.
REQ-005 i_alu_valid  in  1  ALU result present; accepted only when o_stall low.
REQ-006 i_alu_rd  in  AW  destination of ALU result.
REQ-007 i_alu_result  in  N  ALU result.
REQ-008 i_ld_valid  in  1  load request; accepted only when o_ld_busy low.
REQ-009 i_ld_rd  in  AW  load destination; i_ld_addr  in  N  byte address; i_ld_funct3  in  3  load type.
REQ-010 o_ld_busy  out  1  load in flight (FSM not IDLE).
REQ-011 o_mem_req  out  1  data-memory read request; o_mem_addr  out  N  word-aligned address ({addr[N-1:2],2'b00}).
REQ-012 i_mem_gnt  in  1  request accepted; i_mem_rvalid  in  1  read data valid; i_mem_rdata  in  N  read word.
REQ-013 o_rf_we  out  1, o_rf_waddr  out  AW, o_rf_wdata  out  N  register-file write port, registered.
REQ-014 o_stall  out  1  ALU path cannot accept; o_misalign  out  1  misaligned-load pulse.

Function
REQ-015 FSM states IDLE, REQ, WAIT, WB; accepted load captures rd, addr, funct3 and moves IDLE->REQ.
REQ-016 REQ: o_mem_req high, address stable, until i_mem_gnt; gnt -> WAIT (rvalid same cycle as gnt ignored; response expected strictly after grant).
REQ-017 WAIT: on i_mem_rvalid capture extended data -> WB; WB lasts one cycle, drives the load write, then IDLE.
REQ-018 Extension: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte lane addr[1:0], half lane addr[1]; 011/110/111 treated as LW.
REQ-019 ALU write latency one cycle: o_rf_we/waddr/wdata reflect accepted ALU result on next edge.
REQ-020 If an ALU result is accepted in the cycle before WB output (collision), load wins; ALU result held in one-entry pending buffer and written the cycle after.
REQ-021 o_stall high while pending buffer occupied; pending entry drains before any new ALU input is accepted.
REQ-022 rd==0: access performed normally, o_rf_we stays 0 for that write (load or ALU).
REQ-023 o_rf_we is 0 in any cycle with no write; waddr/wdata then hold last value.
REQ-024 i_ld_valid while o_ld_busy high is ignored (not queued).

Reset
REQ-025 While i_arst high: FSM IDLE, pending buffer empty, o_mem_req, o_rf_we, o_stall, o_misalign, o_ld_busy = 0, o_rf_waddr/o_rf_wdata/o_mem_addr = 0.
REQ-026 Reset mid-load aborts the transaction with no write; a later i_mem_rvalid in IDLE is ignored.

Configuration
REQ-027 Macro LOAD_MISALIGN_CHECK_EN: when defined, LH/LHU with addr[0]=1 or LW with addr[1:0]!=0 skip REQ/WAIT, pulse o_misalign for one cycle, perform no write, return to IDLE the next cycle.
REQ-028 Without LOAD_MISALIGN_CHECK_EN: o_misalign tied 0; misaligned loads use the lane rules of REQ-018 (word ignores addr[1:0]).

Verification
REQ-029 LB addr 0x103, rdata 0x80FF_1234, rd=5, gnt after 2 cycles, rvalid 3 cycles later -> o_rf_we=1, waddr=5, wdata=0xFFFF_FF80.
REQ-030 LHU addr 0x102, rdata 0x8001_0000, rd=7 -> wdata=0x0000_8001; LH same -> 0xFFFF_8001.
REQ-031 ALU rd=3 result 0xDEAD_BEEF accepted in cycle before load WB (load rd=4, LW 0x1234_5678) -> write x4=0x1234_5678, then x3=0xDEAD_BEEF next cycle, o_stall high one cycle.
REQ-032 LW rd=0 -> memory access occurs, o_rf_we never asserted; ALU rd=0 -> no write.
REQ-033 i_arst pulsed during WAIT, then rvalid -> no write, o_ld_busy=0, next load completes normally.
REQ-034 With LOAD_MISALIGN_CHECK_EN, LW addr 0x102 -> o_misalign one-cycle pulse, o_mem_req never high, no write; without macro -> request to 0x100, word written.
